// File: rtl/input_dispatch_if.sv
// Byte-stream handshake between the input FIFO read port, the dispatcher and the unit bank.
interface input_dispatch_if #(
    parameter int N_UNITS = 4
);
    logic [7:0]         fifo_dout;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic [N_UNITS-1:0] unit_ready;
    logic [N_UNITS-1:0] unit_full;
    logic [7:0]         unit_dout;
    logic [N_UNITS-1:0] unit_wr_en;
    logic [7:0]         unit_type;
    logic [N_UNITS-1:0] unit_start;

    modport master (
        input  fifo_dout, fifo_empty, unit_ready, unit_full,
        output fifo_rd_en, unit_dout, unit_wr_en, unit_type, unit_start
    );

    modport slave (
        output fifo_dout, fifo_empty, unit_ready, unit_full,
        input  fifo_rd_en, unit_dout, unit_wr_en, unit_type, unit_start
    );
endinterface

// File: rtl/input_dispatch.sv
// Parses a 4-byte header from the FWFT input FIFO, picks a ready unit round-robin
// and streams the payload into it with per-unit backpressure.
module input_dispatch #(
    parameter int         N_UNITS   = 4,
    parameter int         UNIT_BITS = 2,
    parameter logic [7:0] MAGIC     = 8'h5A
) (
    input  logic             clk,
    input  logic             rst_n,
    input_dispatch_if.master bus,
    output logic [15:0]      pkt_count,
    output logic             err,
    output logic             idle
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_TYPE, S_HDR_LEN0, S_HDR_LEN1, S_ARB, S_PAYLOAD, S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           hdr_type_q, hdr_type_d;
    logic [15:0]          len_q, len_d;
    logic [7:0]           unit_type_q, unit_type_d;
    logic [UNIT_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [UNIT_BITS-1:0] sel_q, sel_d;
    logic [15:0]          remaining_q, remaining_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic                 err_q, err_d;
    logic                 idle_q, idle_d;
    logic [N_UNITS-1:0]   start_q, start_d;

    logic                 rd_en;
    logic [N_UNITS-1:0]   wr_en;
    logic                 found;
    logic [UNIT_BITS-1:0] pick;

    // Round-robin search starting just after the last granted unit.
    always_comb begin
        logic [UNIT_BITS-1:0] cand;
        cand  = '0;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N_UNITS; i++) begin
            cand = UNIT_BITS'((int'(rr_ptr_q) + i) % N_UNITS);
            if (!found && bus.unit_ready[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Reads are gated by rst_n so nothing is consumed while reset is held.
    always_comb begin
        rd_en = 1'b0;
        wr_en = '0;
        case (state_q)
            S_IDLE, S_HDR_TYPE, S_HDR_LEN0, S_HDR_LEN1: rd_en = !bus.fifo_empty;
            S_PAYLOAD: rd_en = !bus.fifo_empty && !bus.unit_full[sel_q];
            default:   rd_en = 1'b0;
        endcase
        rd_en = rd_en && rst_n;
        if (state_q == S_PAYLOAD && rd_en) begin
            wr_en[sel_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_type_d  = hdr_type_q;
        len_d       = len_q;
        unit_type_d = unit_type_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        pkt_count_d = pkt_count_q;
        start_d     = '0;
        case (state_q)
            S_IDLE: if (rd_en) begin
                state_d = (bus.fifo_dout == MAGIC) ? S_HDR_TYPE : S_ERROR;
            end
            S_HDR_TYPE: if (rd_en) begin
                hdr_type_d = bus.fifo_dout;
                state_d    = S_HDR_LEN0;
            end
            S_HDR_LEN0: if (rd_en) begin
                len_d[7:0] = bus.fifo_dout;
                state_d    = S_HDR_LEN1;
            end
            S_HDR_LEN1: if (rd_en) begin
                len_d[15:8] = bus.fifo_dout;
                state_d     = ({bus.fifo_dout, len_q[7:0]} == 16'd0) ? S_ERROR : S_ARB;
            end
            S_ARB: if (found) begin
                sel_d          = pick;
                rr_ptr_d       = pick;
                unit_type_d    = hdr_type_q;
                start_d[pick]  = 1'b1;
                remaining_d    = len_q;
                state_d        = S_PAYLOAD;
            end
            S_PAYLOAD: if (rd_en) begin
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_ERROR;
        endcase
        err_d  = (state_d == S_ERROR);
        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hdr_type_q  <= '0;
            len_q       <= '0;
            unit_type_q <= '0;
            rr_ptr_q    <= UNIT_BITS'(N_UNITS - 1);
            sel_q       <= '0;
            remaining_q <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
            idle_q      <= 1'b1;
            start_q     <= '0;
        end else begin
            state_q     <= state_d;
            hdr_type_q  <= hdr_type_d;
            len_q       <= len_d;
            unit_type_q <= unit_type_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
            idle_q      <= idle_d;
            start_q     <= start_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.unit_wr_en = wr_en;
    assign bus.unit_dout  = bus.fifo_dout;
    assign bus.unit_type  = unit_type_q;
    assign bus.unit_start = start_q;
    assign pkt_count      = pkt_count_q;
    assign err            = err_q;
    assign idle           = idle_q;

endmodule

// File: tb/tb_input_dispatch.sv
// Scoreboard bench for input_dispatch: a FIFO model feeds packets, a reference
// model predicts destinations and bytes, a monitor compares every write and start.
module tb_input_dispatch;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] pkt_count;
    logic        err;
    logic        idle;

    input_dispatch_if #(.N_UNITS(N)) bus ();

    input_dispatch #(.N_UNITS(N), .UNIT_BITS(2), .MAGIC(8'h5A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .pkt_count (pkt_count),
        .err       (err),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         unit;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_w[$];
    exp_t       exp_s[$];
    logic [7:0] fq[$];

    int checks = 0, errors = 0, cyc = 0;
    int rr_m = N - 1, pkts_m = 0;
    bit empty_rand = 0, gate = 0, full_tog = 0;
    int full_mode = 0;
    int first_wr = -1, last_wr = -1, n_wr = 0, n_start = 0, n_rd = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = gate || (fq.size() == 0);
        bus.fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: the destination is the first unit in mask after the last grant.
    task automatic send_pkt(input logic [7:0] ty, input int len, input logic [N-1:0] mask,
                            input bit fixed);
        int         dest;
        logic [7:0] b;
        dest = -1;
        for (int i = 1; i <= N; i++) begin
            if (dest < 0 && mask[(rr_m + i) % N]) dest = (rr_m + i) % N;
        end
        fq.push_back(8'h5A);
        fq.push_back(ty);
        fq.push_back(8'(len));
        fq.push_back(8'(len >> 8));
        rr_m = dest;
        exp_s.push_back('{unit: dest, b: ty});
        for (int k = 0; k < len; k++) begin
            b = fixed ? 8'(8'hAA + 8'h11 * k) : 8'($urandom);
            fq.push_back(b);
            exp_w.push_back('{unit: dest, b: b});
        end
        pkts_m = (pkts_m + 1) % 65536;
        drive_fifo();
    endtask

    task automatic wait_done(input int maxc, input string name);
        int k;
        k = 0;
        while (!(fq.size() == 0 && exp_w.size() == 0 && exp_s.size() == 0 && idle) && k < maxc) begin
            tick();
            k++;
        end
        check(k < maxc, name, k, maxc);
        check(pkt_count == 16'(pkts_m), {name, "_pkt_count"}, int'(pkt_count), pkts_m);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check(bus.fifo_rd_en == 1'b0, "rst_rd_en", int'(bus.fifo_rd_en), 0);
        check(bus.unit_wr_en == '0, "rst_wr_en", int'(bus.unit_wr_en), 0);
        check(bus.unit_start == '0, "rst_start", int'(bus.unit_start), 0);
        check(bus.unit_type == 8'h00, "rst_type", int'(bus.unit_type), 0);
        check(pkt_count == 16'd0, "rst_pkt_count", int'(pkt_count), 0);
        check(err == 1'b0, "rst_err", int'(err), 0);
        check(idle == 1'b1, "rst_idle", int'(idle), 1);
        tick();
        fq.delete();
        exp_w.delete();
        exp_s.delete();
        rr_m   = N - 1;
        pkts_m = 0;
        drive_fifo();
        rst_n = 1'b1;
        tick();
        check(idle == 1'b1, "post_rst_idle", int'(idle), 1);
        check(pkt_count == 16'd0, "post_rst_pkt_count", int'(pkt_count), 0);
    endtask

    // Monitor and FIFO/unit environment.
    initial begin : mon
        logic pop_now;
        int   u;
        exp_t e;
        forever begin
            @(negedge clk);
            pop_now = bus.fifo_rd_en;
            if (pop_now) begin
                n_rd++;
                check(!bus.fifo_empty, "rd_while_empty", int'(bus.fifo_empty), 0);
            end
            if (bus.unit_wr_en != '0) begin
                u = 0;
                for (int i = 0; i < N; i++) if (bus.unit_wr_en[i]) u = i;
                check($onehot(bus.unit_wr_en), "wr_onehot", int'(bus.unit_wr_en), 1 << u);
                check((bus.unit_wr_en & bus.unit_full) == '0, "wr_while_full",
                      int'(bus.unit_full), 0);
                check(pop_now, "wr_without_rd", int'(pop_now), 1);
                if (exp_w.size() == 0) begin
                    check(1'b0, "unexpected_wr", u, -1);
                end else begin
                    e = exp_w.pop_front();
                    check(u == e.unit, "wr_unit", u, e.unit);
                    check(bus.unit_dout == e.b, "wr_byte", int'(bus.unit_dout), int'(e.b));
                end
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (bus.unit_start != '0) begin
                u = 0;
                for (int i = 0; i < N; i++) if (bus.unit_start[i]) u = i;
                check($onehot(bus.unit_start), "start_onehot", int'(bus.unit_start), 1 << u);
                if (exp_s.size() == 0) begin
                    check(1'b0, "unexpected_start", u, -1);
                end else begin
                    e = exp_s.pop_front();
                    check(u == e.unit, "start_unit", u, e.unit);
                    check(bus.unit_type == e.b, "unit_type", int'(bus.unit_type), int'(e.b));
                end
                n_start++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pop_now && fq.size() != 0) void'(fq.pop_front());
            gate = empty_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            case (full_mode)
                1:       bus.unit_full = N'($urandom_range(0, 15) & $urandom_range(0, 15));
                2: begin
                    if (cyc % 3 == 0) full_tog = !full_tog;
                    bus.unit_full = {N{full_tog}};
                end
                default: bus.unit_full = '0;
            endcase
            drive_fifo();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int             k, s0, w0, r0;
        logic [N-1:0]   mask;
        logic [15:0]    pk0;
        bus.unit_ready = '1;
        bus.unit_full  = '0;
        drive_fifo();
        #3;
        do_reset();

        // Single 3-byte packet, cycle-exact completion
        first_wr = -1;
        send_pkt(8'h07, 3, 4'hF, 1'b1);
        repeat (7) tick();
        check(idle == 1'b0, "t1_busy_at_7", int'(idle), 0);
        tick();
        check(idle == 1'b1, "t1_idle_at_8", int'(idle), 1);
        check(pkt_count == 16'd1, "t1_pkt_count", int'(pkt_count), 1);
        check(last_wr - first_wr == 2, "t1_consecutive", last_wr - first_wr, 2);
        wait_done(20, "t1_done");

        // Four back-to-back 1-byte packets
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(8'(8'h10 + i), 1, 4'hF, 1'b0);
        wait_done(60, "t2_done");

        // Nobody ready, then only unit 2, then all
        do_reset();
        bus.unit_ready = '0;
        s0 = n_start;
        send_pkt(8'h33, 5, 4'b0100, 1'b0);
        repeat (10) tick();
        check(n_start == s0, "arb_hold_no_start", n_start - s0, 0);
        check(idle == 1'b0, "arb_hold_busy", int'(idle), 0);
        bus.unit_ready = 4'b0100;
        k = 0;
        while (n_start == s0 && k < 20) begin tick(); k++; end
        check(k < 20, "arb_release", k, 20);
        bus.unit_ready = 4'hF;
        send_pkt(8'h44, 3, 4'hF, 1'b0);
        wait_done(60, "t3_done");

        // Random packets, ready masks, empty gaps and unit backpressure
        empty_rand = 1;
        full_mode  = 1;
        for (int p = 0; p < 20; p++) begin
            mask = N'($urandom_range(1, 15));
            bus.unit_ready = mask;
            send_pkt(8'($urandom), $urandom_range(1, 20), mask, 1'b0);
            wait_done(500, "rand_done");
        end

        // Long payload with full toggling every third cycle
        bus.unit_ready = 4'hF;
        full_mode = 2;
        w0  = n_wr;
        pk0 = pkt_count;
        send_pkt(8'hC3, 300, 4'hF, 1'b0);
        wait_done(3000, "long_done");
        check(n_wr - w0 == 300, "long_writes", n_wr - w0, 300);
        check(pkt_count == pk0 + 16'd1, "long_pkt_inc", int'(pkt_count - pk0), 1);
        empty_rand = 0;
        full_mode  = 0;

        // Reset in the middle of a 10-byte payload
        send_pkt(8'h5E, 10, 4'hF, 1'b0);
        k = 0;
        while (exp_w.size() > 5 && k < 40) begin tick(); k++; end
        check(k < 40, "mid_payload_reached", k, 40);
        do_reset();

        // Bad magic byte
        fq.push_back(8'h5B);
        drive_fifo();
        check(err == 1'b0, "err_before", int'(err), 0);
        tick();
        check(err == 1'b1, "err_after_1", int'(err), 1);
        r0 = n_rd;
        fq.push_back(8'h5A);
        fq.push_back(8'h01);
        drive_fifo();
        repeat (5) tick();
        check(n_rd == r0, "err_no_reads", n_rd - r0, 0);
        check(idle == 1'b0, "err_not_idle", int'(idle), 0);
        do_reset();

        // Zero-length header
        s0 = n_start;
        fq.push_back(8'h5A);
        fq.push_back(8'h01);
        fq.push_back(8'h00);
        fq.push_back(8'h00);
        drive_fifo();
        repeat (8) tick();
        check(err == 1'b1, "zero_len_err", int'(err), 1);
        check(n_start == s0, "zero_len_no_start", n_start - s0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
